// File: rtl/rate_tick_pkg.sv
// Shared encodings and half-period helper for the slow-rate tick generator.
package rate_tick_pkg;

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned STEP_W = 8;

  // Rate-select encoding.
  localparam logic [SEL_W-1:0] RATE_SEL_1HZ  = 2'd0;
  localparam logic [SEL_W-1:0] RATE_SEL_2HZ  = 2'd1;
  localparam logic [SEL_W-1:0] RATE_SEL_5HZ  = 2'd2;
  localparam logic [SEL_W-1:0] RATE_SEL_10HZ = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Output rate in Hz for a select value.
  function automatic int unsigned rate_hz(input logic [SEL_W-1:0] sel);
    int unsigned r;
    case (sel)
      RATE_SEL_1HZ:  r = 32'd1;
      RATE_SEL_2HZ:  r = 32'd2;
      RATE_SEL_5HZ:  r = 32'd5;
      default:       r = 32'd10;
    endcase
    return r;
  endfunction

  // Half period in clock cycles: clk_hz / (2 * rate), integer division.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input logic [SEL_W-1:0] sel);
    return clk_hz / (32'd2 * rate_hz(sel));
  endfunction

endpackage

// File: rtl/half_period_counter.sv
// Half-period counter: counts while enabled and flags the H-1 wrap cycle.
module half_period_counter #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             wrap_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrap fires in the enabled cycle where the count sits at H-1.
  assign wrap_c = en_i && (cnt_q == (load_i - CNT_W'(1)));

  // Next count: clear wins, otherwise increment with exact wrap to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rate_tick_ctrl.sv
// Run controller: start/stop FSM, phase/tick generation and counted-run tracking.
module rate_tick_ctrl
  import rate_tick_pkg::*;
#(
  parameter int unsigned CLK_HZ = 125_000_000,
  parameter int unsigned CNT_W  = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [SEL_W-1:0]  rate_sel,
  input  logic [STEP_W-1:0] step_count,
  output logic              phase,
  output logic              tick,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_left
);

  localparam logic [CNT_W-1:0] H_1HZ  = CNT_W'(half_period(CLK_HZ, RATE_SEL_1HZ));
  localparam logic [CNT_W-1:0] H_2HZ  = CNT_W'(half_period(CLK_HZ, RATE_SEL_2HZ));
  localparam logic [CNT_W-1:0] H_5HZ  = CNT_W'(half_period(CLK_HZ, RATE_SEL_5HZ));
  localparam logic [CNT_W-1:0] H_10HZ = CNT_W'(half_period(CLK_HZ, RATE_SEL_10HZ));

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  rate_q, rate_d;
  logic              counted_q, counted_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              phase_q, phase_d;
  logic              tick_q, tick_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cnt_en, cnt_clr, wrap;
  logic [CNT_W-1:0]  half_load;

  // Half-period constant selected by the latched rate.
  always_comb begin
    case (rate_q)
      RATE_SEL_1HZ: half_load = H_1HZ;
      RATE_SEL_2HZ: half_load = H_2HZ;
      RATE_SEL_5HZ: half_load = H_5HZ;
      default:      half_load = H_10HZ;
    endcase
  end

  half_period_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .load_i (half_load),
    .wrap_c (wrap)
  );

  // Next-state and registered-output logic; stop beats start and ticks.
  always_comb begin
    state_d   = state_q;
    rate_d    = rate_q;
    counted_d = counted_q;
    steps_d   = steps_q;
    phase_d   = phase_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = 1'b0;
        if (start && !stop) begin
          rate_d    = rate_sel;
          counted_d = (step_count != '0);
          steps_d   = step_count;
          cnt_clr   = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          phase_d = 1'b0;
          state_d = ST_IDLE;
        end else if (counted_q && (steps_q == '0)) begin
          // Final tick is visible this cycle; completion follows.
          phase_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
          if (wrap) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
              tick_d = 1'b1;
              if (counted_q) steps_d = steps_q - STEP_W'(1);
            end
          end
        end
      end
      ST_DONE: begin
        phase_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        phase_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rate_q    <= RATE_SEL_1HZ;
      counted_q <= 1'b0;
      steps_q   <= '0;
      phase_q   <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rate_q    <= rate_d;
      counted_q <= counted_d;
      steps_q   <= steps_d;
      phase_q   <= phase_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign phase      = phase_q;
  assign tick       = tick_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = steps_q;

endmodule

// File: tb/tb_rate_tick_ctrl.sv
// Directed bench for rate_tick_ctrl at CLK_HZ = 40 (H = 20/10/4/2).
module tb_rate_tick_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop;
  logic [1:0] rate_sel;
  logic [7:0] step_count;
  logic       phase, tick, busy, done;
  logic [7:0] steps_left;

  int n_cmp = 0;
  int n_err = 0;

  rate_tick_ctrl #(
    .CLK_HZ (40),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .rate_sel   (rate_sel),
    .step_count (step_count),
    .phase      (phase),
    .tick       (tick),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic [1:0] rate;
    logic [7:0] steps;
    logic       ph;
    logic       tk;
    logic       bsy;
    logic       dn;
    logic [7:0] sl;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic st, input logic sp, input logic [1:0] r,
                              input logic [7:0] s, input logic ph, input logic tk,
                              input logic bsy, input logic dn, input logic [7:0] sl);
    vec_t v;
    v.start = st; v.stop = sp; v.rate = r; v.steps = s;
    v.ph = ph; v.tk = tk; v.bsy = bsy; v.dn = dn; v.sl = sl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ph, input logic tk, input logic bsy,
                         input logic dn, input logic [7:0] sl);
    chk({tag, " phase"}, 8'(phase), 8'(ph));
    chk({tag, " tick"},  8'(tick),  8'(tk));
    chk({tag, " busy"},  8'(busy),  8'(bsy));
    chk({tag, " done"},  8'(done),  8'(dn));
    chk({tag, " steps_left"}, steps_left, sl);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Row k: inputs during one cycle, expected outputs in the following cycle.
    tbl[0]  = mk(1, 1, 3, 3,  0, 0, 0, 0, 0);  // start+stop in IDLE
    tbl[1]  = mk(0, 1, 3, 3,  0, 0, 0, 0, 0);  // stop alone in IDLE
    tbl[2]  = mk(1, 0, 3, 3,  0, 0, 1, 0, 3);  // c0 start -> c1
    tbl[3]  = mk(0, 0, 0, 0,  0, 0, 1, 0, 3);  // c2
    tbl[4]  = mk(0, 0, 0, 0,  1, 1, 1, 0, 2);  // c3 tick
    tbl[5]  = mk(1, 0, 0, 9,  1, 0, 1, 0, 2);  // c4, start ignored
    tbl[6]  = mk(0, 0, 0, 0,  0, 0, 1, 0, 2);  // c5
    tbl[7]  = mk(0, 0, 0, 0,  0, 0, 1, 0, 2);  // c6
    tbl[8]  = mk(0, 0, 0, 0,  1, 1, 1, 0, 1);  // c7 tick
    tbl[9]  = mk(0, 0, 0, 0,  1, 0, 1, 0, 1);  // c8
    tbl[10] = mk(0, 0, 0, 0,  0, 0, 1, 0, 1);  // c9
    tbl[11] = mk(0, 0, 0, 0,  0, 0, 1, 0, 1);  // c10
    tbl[12] = mk(0, 0, 0, 0,  1, 1, 1, 0, 0);  // c11 last tick
    tbl[13] = mk(0, 0, 0, 0,  0, 0, 1, 1, 0);  // c12 done
    tbl[14] = mk(1, 0, 3, 1,  0, 0, 0, 0, 0);  // c13 idle, start in DONE ignored
    tbl[15] = mk(1, 0, 3, 1,  0, 0, 1, 0, 1);  // start at t+2 -> c14
    tbl[16] = mk(0, 0, 0, 0,  0, 0, 1, 0, 1);  // c15
    tbl[17] = mk(0, 0, 0, 0,  1, 1, 1, 0, 0);  // c16 single tick
    tbl[18] = mk(0, 0, 0, 0,  0, 0, 1, 1, 0);  // c17 done
    tbl[19] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0);  // c18 idle

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; rate_sel = 2'd0; step_count = 8'd0;

    // Reset held for three cycles.
    repeat (3) cyc();
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("post_reset%0d busy", i), 8'(busy), 8'd0);
    end

    // Counted runs, restart at t+2 and IDLE corner cases from the table.
    for (int i = 0; i < NVEC; i++) begin
      start = tbl[i].start; stop = tbl[i].stop;
      rate_sel = tbl[i].rate; step_count = tbl[i].steps;
      cyc();
      chk_all($sformatf("vec%0d", i), tbl[i].ph, tbl[i].tk, tbl[i].bsy, tbl[i].dn, tbl[i].sl);
    end
    start = 1'b0; stop = 1'b0;

    // Free-run at H=4: rise at c5, period 8, 4 high.
    rate_sel = 2'd2; step_count = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      logic eph, etk;
      eph = (c >= 5) && (((c - 5) % 8) < 4);
      etk = (c >= 5) && (((c - 5) % 8) == 0);
      chk_all($sformatf("free c%0d", c), eph, etk, 1, 0, 0);
      if (c < 100) cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk_all("free stop", 0, 0, 0, 0, 0);

    // Stop collides with the first wrap at H=2.
    rate_sel = 2'd3; step_count = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk_all("collide c3", 0, 0, 0, 0, 0);
    cyc();
    chk_all("collide c4", 0, 0, 0, 0, 0);

    // Stop in a counted run keeps steps_left.
    rate_sel = 2'd3; step_count = 8'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk_all("stop counted c5", 0, 0, 0, 0, 2);
    cyc();
    chk_all("stop counted c6", 0, 0, 0, 0, 2);

    // Latching: rate change and start pulses during RUN are ignored.
    rate_sel = 2'd0; step_count = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      chk($sformatf("latch c%0d tick", c), 8'(tick), 8'(c == 21));
      chk($sformatf("latch c%0d phase", c), 8'(phase), 8'(c == 21));
      if (c == 5) rate_sel = 2'd3;
      start = (c == 8);
      if (c < 21) cyc();
    end
    start = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk_all("latch stop", 0, 0, 0, 0, 0);

    // Reset in cycle 6 of a counted run suppresses the c7 tick.
    rate_sel = 2'd3; step_count = 8'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk_all("midreset c7", 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_all($sformatf("midreset after%0d", i), 0, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rate_tick_ctrl.md
# rate_tick_ctrl

Run controller for the design's slow-rate event generator, clocked from the 125 MHz system clock. It takes start/stop commands, selects one of four output rates (1, 2, 5 or 10 Hz), and produces a square-wave phase output together with a single-cycle tick on each rising phase edge. It can run a fixed number of ticks and then report completion, or run freely until stopped. Display, blink and stepping logic consume its outputs instead of each owning a private divider.

## Interface
Parameters:
- `CLK_HZ`, default 125_000_000: system clock frequency. Benches override it with a small value, e.g. 40.
- `CNT_W`, default 26: half-period counter width. Must hold `CLK_HZ/2 - 1`.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  start request, sampled in IDLE only.
- `stop`  in  1  abort request. Has priority over `start` and over tick generation.
- `rate_sel`  in  2  rate select: 0 = 1 Hz, 1 = 2 Hz, 2 = 5 Hz, 3 = 10 Hz. Latched on start.
- `step_count`  in  8  number of ticks to run. 0 means free-run. Latched on start.
- `phase`  out  1  square wave at the selected rate, 50 % duty.
- `tick`  out  1  one-cycle pulse, coincident with each 0→1 transition of `phase`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after the final tick of a counted run.
- `steps_left`  out  8  ticks remaining in a counted run. Held at 0 in free-run.

## Operation
- Half period H = `CLK_HZ / (2 * rate)`, using integer division. Each value comes from a constant table indexed by the latched `rate_sel`.
- States: IDLE, RUN, DONE.
- IDLE:
  - `start` = 1 and `stop` = 0 → latch `rate_sel` and `step_count`, clear the counter, set `steps_left` = `step_count`, go to RUN.
  - Otherwise stay in IDLE.
  - `stop` in IDLE has no effect.
- RUN:
  - The counter increments every cycle.
  - When counter == H-1: counter ← 0 and `phase` toggles.
  - A toggle from 0 to 1 also registers `tick` = 1 for one cycle.
  - In a counted run, each tick decrements `steps_left`. The tick that brings it to 0 sends the FSM to DONE.
  - `start`, `rate_sel` and `step_count` are ignored while in RUN.
- RUN, `stop` = 1 → go to IDLE. `phase` and `tick` are forced to 0, `done` is not asserted, and `steps_left` keeps its current value.
- DONE lasts exactly one cycle. `done` = 1, `phase` = 0, then the FSM returns to IDLE.
- Free-run (`step_count` = 0) never enters DONE and ends only on `stop`.
- All outputs are registered, with no combinational path from inputs to outputs.

## Timing
- Reset (`rst_n` = 0 at a rising edge):
  - state → IDLE.
  - `phase`, `tick`, `busy`, `done` = 0.
  - `steps_left` = 0.
  - counter = 0.
- Reset asserted mid-run behaves identically to power-up reset. It produces no `done` and no trailing tick.
- Start latency: `start` sampled in cycle 0 → `busy` = 1 from cycle 1. The first `tick` and the first rise of `phase` occur in cycle H+1. After that, ticks repeat every 2H cycles.
- Completion: the last tick occurs in cycle t. Then `done` = 1 and `phase` = 0 in cycle t+1, and `busy` = 0 from cycle t+2.
- A new `start` is accepted from cycle t+2 onward.
- `stop` sampled in cycle s while in RUN → `busy`, `phase` and `tick` are all 0 in cycle s+1.
- If `stop` is sampled in the same cycle as a toggle, `stop` wins and no tick is emitted.
- `start` and `stop` asserted together in IDLE → the FSM stays in IDLE.
- Counter wrap is exact at H-1. The counter never exceeds H-1, and no count is lost at a wrap.

## Structure
- Shared package `rate_tick_pkg` holds:
  - the rate-select encoding constants;
  - the state encoding;
  - a function that returns H for a given `CLK_HZ` and select value.
- One sub-module, `half_period_counter`, contains:
  - the `CNT_W` counter with an enable;
  - a synchronous clear;
  - a load-value compare that pulses `wrap` at H-1.
- `rate_tick_ctrl` owns the FSM, the `phase`/`tick`/`done` registers and `steps_left`.

## Test plan
All scenarios use `CLK_HZ` = 40, so H = 20 / 10 / 4 / 2 for `rate_sel` = 0 / 1 / 2 / 3.
- Reset check: hold `rst_n` = 0 for 3 cycles → all outputs 0. Release → `busy` stays 0 until `start`.
- Counted run: `rate_sel` = 3, `step_count` = 3, `start` in cycle 0 → ticks in cycles 3, 7 and 11; `done` in cycle 12; `busy` = 0 from cycle 13; `steps_left` goes 3→2→1→0.
- Free-run: `rate_sel` = 2, `step_count` = 0, run for 100 cycles → `phase` period is 8 cycles with 4 high; `tick` occurs once per period; `steps_left` = 0; `done` never asserts.
- Stop collides with a tick: free-run at `rate_sel` = 3 with `stop` in cycle 2 → cycle 3 has `tick` = 0, `phase` = 0 and `busy` = 0, with no `done`.
- Latching: start at `rate_sel` = 0, then change `rate_sel` to 3 in cycle 5 → the first tick is still in cycle 21. `start` pulses during RUN are ignored.
- Reset mid-run: assert `rst_n` = 0 in cycle 6 of a counted run → outputs return to reset values the next cycle, with no `done` and no tick.
